prio_encoder_pipe: RTL and testbench

Parametrised, registered priority encoder with a valid/ready handshake on both sides.
- Accepts a WIDTH-bit request vector and returns the index of the winning set bit, a no-request flag and a popcount.
- Two selection modes: fixed lowest-index priority, or round-robin with a rotating start pointer.
- Generalises the team's 8-to-3 combinational encoder for use in request-arbitration paths, with full-throughput streaming and backpressure.

---
 rtl/prio_encoder_pipe.sv | 96 +++++++++
 tb/tb_prio_encoder_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_pipe.sv
// Registered priority encoder with valid/ready handshake on both sides.
// Reports the winning index (fixed lowest-first or round-robin), a no-request flag and a popcount.
module prio_encoder_pipe #(
  parameter int WIDTH   = 8,
  parameter int RR_MODE = 0,
  localparam int IDX_W  = $clog2(WIDTH),
  localparam int CNT_W  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_none,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [IDX_W:0]   WIDTH_L = (IDX_W + 1)'(WIDTH);
  localparam logic [IDX_W-1:0] LAST_L  = IDX_W'(WIDTH - 1);

  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic             r_none;
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] r_ptr;

  logic             w_accept;
  logic [IDX_W-1:0] w_start;
  logic [WIDTH-1:0] w_rot;
  logic [IDX_W-1:0] w_off;
  logic             w_any;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_win;
  logic [IDX_W-1:0] w_next_ptr;
  logic [CNT_W-1:0] w_pop;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_start  = (RR_MODE != 0) ? r_ptr : '0;

  // Rotate so the search start sits at bit 0, then pick the lowest set bit of the rotated vector.
  always_comb begin
    w_rot = WIDTH'({in_vec, in_vec} >> w_start);
    w_off = '0;
    w_any = 1'b0;
    for (int unsigned k = WIDTH; k > 0; k--) begin
      if (w_rot[k-1]) begin
        w_off = IDX_W'(k - 1);
        w_any = 1'b1;
      end
    end
  end

  // Map the rotated offset back to an absolute index; explicit wrap handles non-power-of-two widths.
  assign w_sum      = {1'b0, w_start} + {1'b0, w_off};
  assign w_win      = (w_sum >= WIDTH_L) ? IDX_W'(w_sum - WIDTH_L) : IDX_W'(w_sum);
  assign w_next_ptr = (w_win == LAST_L) ? '0 : w_win + 1'b1;

  always_comb begin
    w_pop = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      w_pop = w_pop + CNT_W'(in_vec[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_none  <= 1'b0;
      r_count <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_idx   <= w_any ? w_win : '0;
        r_none  <= !w_any;
        r_count <= w_pop;
        if ((RR_MODE != 0) && w_any) begin
          r_ptr <= w_next_ptr;
        end
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign out_none  = r_none;
  assign out_count = r_count;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Bench for prio_encoder_pipe: three instances (W8 fixed, W8 round-robin, W5 round-robin)
// checked every cycle against a behavioural model, plus directed literal expectations.
module tb_prio_encoder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v [3];
  logic [63:0] vec_v [3];
  logic        vld_v [3];
  logic        ordy_v[3];

  logic       rdy0, val0, none0;
  logic [2:0] idx0;
  logic [3:0] cnt0;
  logic       rdy1, val1, none1;
  logic [2:0] idx1;
  logic [3:0] cnt1;
  logic       rdy2, val2, none2;
  logic [2:0] idx2;
  logic [2:0] cnt2;

  prio_encoder_pipe #(.WIDTH(8), .RR_MODE(0)) u0 (
    .clk(clk), .rst(rst_v[0]), .in_vec(vec_v[0][7:0]), .in_valid(vld_v[0]), .in_ready(rdy0),
    .out_idx(idx0), .out_none(none0), .out_count(cnt0), .out_valid(val0), .out_ready(ordy_v[0]));
  prio_encoder_pipe #(.WIDTH(8), .RR_MODE(1)) u1 (
    .clk(clk), .rst(rst_v[1]), .in_vec(vec_v[1][7:0]), .in_valid(vld_v[1]), .in_ready(rdy1),
    .out_idx(idx1), .out_none(none1), .out_count(cnt1), .out_valid(val1), .out_ready(ordy_v[1]));
  prio_encoder_pipe #(.WIDTH(5), .RR_MODE(1)) u2 (
    .clk(clk), .rst(rst_v[2]), .in_vec(vec_v[2][4:0]), .in_valid(vld_v[2]), .in_ready(rdy2),
    .out_idx(idx2), .out_none(none2), .out_count(cnt2), .out_valid(val2), .out_ready(ordy_v[2]));

  function automatic int wof(int d);
    return (d == 2) ? 5 : 8;
  endfunction

  function automatic bit rrof(int d);
    return d != 0;
  endfunction

  logic [63:0] o_idx[3], o_cnt[3];
  logic        o_rdy[3], o_val[3], o_none[3];
  always_comb begin
    o_idx[0] = 64'(idx0); o_cnt[0] = 64'(cnt0); o_rdy[0] = rdy0; o_val[0] = val0; o_none[0] = none0;
    o_idx[1] = 64'(idx1); o_cnt[1] = 64'(cnt1); o_rdy[1] = rdy1; o_val[1] = val1; o_none[1] = none1;
    o_idx[2] = 64'(idx2); o_cnt[2] = 64'(cnt2); o_rdy[2] = rdy2; o_val[2] = val2; o_none[2] = none2;
  end

  // Behavioural model: one entry per instance.
  bit m_val[3], m_none[3];
  int m_idx[3], m_cnt[3], m_ptr[3];

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int w, win, start, j;
      logic [63:0] v;
      bit acc;
      w     = wof(d);
      v     = vec_v[d] & ((64'd1 << w) - 64'd1);
      acc   = vld_v[d] && (!m_val[d] || ordy_v[d]);
      start = rrof(d) ? m_ptr[d] : 0;
      win   = -1;
      for (int k = 0; k < w; k++) begin
        j = (start + k) % w;
        if (win < 0 && v[j]) win = j;
      end
      if (rst_v[d]) begin
        m_val[d] <= 1'b0; m_idx[d] <= 0; m_none[d] <= 1'b0; m_cnt[d] <= 0; m_ptr[d] <= 0;
      end else if (acc) begin
        m_val[d]  <= 1'b1;
        m_none[d] <= (v == 64'd0);
        m_cnt[d]  <= $countones(v);
        m_idx[d]  <= (win < 0) ? 0 : win;
        if (rrof(d) && win >= 0) m_ptr[d] <= (win + 1) % w;
      end else if (m_val[d] && ordy_v[d]) begin
        m_val[d] <= 1'b0;
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d", name, act, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("d%0d_ready", d), 64'(o_rdy[d]), 64'(!m_val[d] || ordy_v[d]));
        chk($sformatf("d%0d_valid", d), 64'(o_val[d]), 64'(m_val[d]));
        chk($sformatf("d%0d_idx", d),   o_idx[d],      64'(m_idx[d]));
        chk($sformatf("d%0d_none", d),  64'(o_none[d]), 64'(m_none[d]));
        chk($sformatf("d%0d_count", d), o_cnt[d],      64'(m_cnt[d]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_seq[10];
    for (int d = 0; d < 3; d++) begin
      rst_v[d] = 1'b1; vld_v[d] = 1'b1; vec_v[d] = '1; ordy_v[d] = 1'b1;
    end

    // Reset held two cycles with a pending all-ones request
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_valid", 64'(val0), 64'd0);
    chk("rst_idx",   64'(idx0), 64'd0);
    chk("rst_count", 64'(cnt0), 64'd0);
    chk("rst_none",  64'(none0), 64'd0);
    chk("rst_ready", 64'(rdy0), 64'd1);
    for (int d = 0; d < 3; d++) begin
      rst_v[d] = 1'b0; vld_v[d] = 1'b0; vec_v[d] = '0;
    end
    tick();
    chk("post_rst_valid", 64'(val0), 64'd0);
    chk("post_rst_ready", 64'(rdy0), 64'd1);

    // Fixed priority single vectors
    vld_v[0] = 1'b1; vec_v[0] = 64'h28;
    tick();
    chk("fx_28_valid", 64'(val0), 64'd1);
    chk("fx_28_idx",   64'(idx0), 64'd3);
    chk("fx_28_count", 64'(cnt0), 64'd2);
    chk("fx_28_none",  64'(none0), 64'd0);
    vec_v[0] = 64'h00;
    tick();
    chk("fx_00_none",  64'(none0), 64'd1);
    chk("fx_00_idx",   64'(idx0), 64'd0);
    chk("fx_00_count", 64'(cnt0), 64'd0);
    vec_v[0] = 64'h80;
    tick();
    chk("fx_80_idx",   64'(idx0), 64'd7);
    chk("fx_80_count", 64'(cnt0), 64'd1);
    vld_v[0] = 1'b0;
    tick();

    // Backpressure: result held, new vector waits
    ordy_v[0] = 1'b0; vld_v[0] = 1'b1; vec_v[0] = 64'h04;
    tick();
    vec_v[0] = 64'h10;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_idx",   64'(idx0), 64'd2);
      chk("bp_hold_ready", 64'(rdy0), 64'd0);
      chk("bp_hold_valid", 64'(val0), 64'd1);
    end
    ordy_v[0] = 1'b1;
    tick();
    chk("bp_release_idx",   64'(idx0), 64'd4);
    chk("bp_release_valid", 64'(val0), 64'd1);
    vld_v[0] = 1'b0;
    tick();

    // Round-robin wrap on 8'b1000_0001
    vld_v[1] = 1'b1; vec_v[1] = 64'h81;
    exp_seq[0] = 0; exp_seq[1] = 7; exp_seq[2] = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rr_wrap_idx",   64'(idx1), 64'(exp_seq[i]));
      chk("rr_wrap_count", 64'(cnt1), 64'd2);
      chk("rr_wrap_ptr",   64'(m_ptr[1]), 64'((i % 2 == 0) ? 1 : 0));
    end
    vld_v[1] = 1'b0; rst_v[1] = 1'b1;
    tick();
    rst_v[1] = 1'b0;

    // Round-robin sweep with a zero vector inserted part-way
    vld_v[1] = 1'b1;
    exp_seq = '{0, 1, 2, 3, -1, 4, 5, 6, 7, 0};
    for (int i = 0; i < 10; i++) begin
      vec_v[1] = (i == 4) ? 64'h00 : 64'hFF;
      tick();
      chk("rr_sweep_valid", 64'(val1), 64'd1);
      if (i == 4) begin
        chk("rr_sweep_none", 64'(none1), 64'd1);
        chk("rr_sweep_ptr",  64'(m_ptr[1]), 64'd4);
      end else begin
        chk("rr_sweep_idx",   64'(idx1), 64'(exp_seq[i]));
        chk("rr_sweep_count", 64'(cnt1), 64'd8);
      end
    end
    vld_v[1] = 1'b0;
    tick();

    // Width 5: wrap, hold, mid-operation reset
    vld_v[2] = 1'b1; vec_v[2] = 64'h10;
    tick();
    chk("w5_idx4", 64'(idx2), 64'd4);
    chk("w5_ptr0", 64'(m_ptr[2]), 64'd0);
    vld_v[2] = 1'b0; ordy_v[2] = 1'b0;
    tick();
    chk("w5_hold_valid", 64'(val2), 64'd1);
    rst_v[2] = 1'b1;
    tick();
    chk("w5_rst_valid", 64'(val2), 64'd0);
    chk("w5_rst_idx",   64'(idx2), 64'd0);
    rst_v[2] = 1'b0; ordy_v[2] = 1'b1; vld_v[2] = 1'b1; vec_v[2] = 64'h11;
    tick();
    chk("w5_after_idx",   64'(idx2), 64'd0);
    chk("w5_after_count", 64'(cnt2), 64'd2);
    vld_v[2] = 1'b0;
    tick();

    // Randomized traffic on all instances
    for (int n = 0; n < 2000; n++) begin
      for (int d = 0; d < 3; d++) begin
        int sel;
        rst_v[d]  = ($urandom_range(0, 63) == 0);
        vld_v[d]  = ($urandom_range(0, 3) != 0);
        ordy_v[d] = ($urandom_range(0, 2) != 0);
        sel = $urandom_range(0, 7);
        if (sel == 0)      vec_v[d] = '0;
        else if (sel == 1) vec_v[d] = '1;
        else if (sel == 2) vec_v[d] = 64'd1 << $urandom_range(0, wof(d) - 1);
        else               vec_v[d] = {$urandom, $urandom};
      end
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      rst_v[d] = 1'b0; vld_v[d] = 1'b0; ordy_v[d] = 1'b1;
    end
    tick();
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
